// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result sources and CDB broadcast bundle
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;

    // Functional-unit side: presents results, observes accepts and the broadcast
    modport master (
        output src_valid, src_tag, src_data,
        input  src_ready, cdb_valid, cdb_tag, cdb_data
    );

    // Arbiter side
    modport slave (
        input  src_valid, src_tag, src_data,
        output src_ready, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with one holding slot per source
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] accept;
    logic [TAG_W-1:0]   slot_tag  [NUM_SRC];
    logic [DATA_W-1:0]  slot_data [NUM_SRC];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               gnt_valid;
    logic [PTR_W:0]     scan;
    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;

    // Rotating priority scan from rr_ptr; highest k first so the nearest pending slot wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(NUM_SRC)) begin
                scan = scan - (PTR_W+1)'(NUM_SRC);
            end
            if (pending[scan[PTR_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan[PTR_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time
    always_comb begin
        next_ptr = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // A granted slot frees up this cycle, so it can take the next result at once
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign grant[i]  = gnt_valid & (gnt_idx == PTR_W'(i));
        assign ready[i]  = ~flush & (~pending[i] | grant[i]);
        assign accept[i] = bus.src_valid[i] & ready[i];
    end

    // Slot occupancy, broadcast register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            pending     <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            cdb_valid_q <= gnt_valid;
            if (gnt_valid) begin
                cdb_tag_q  <= slot_tag[gnt_idx];
                cdb_data_q <= slot_data[gnt_idx];
                rr_ptr     <= next_ptr;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    pending[i]   <= 1'b1;
                    slot_tag[i]  <= bus.src_tag[i*TAG_W +: TAG_W];
                    slot_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.src_ready = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_SRC(4), .TAG_W(3), .DATA_W(32)) bus ();

    cdb_arbiter #(.NUM_SRC(4), .TAG_W(3), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    bit          d_rst;
    bit          d_flush;
    logic [3:0]  d_valid;
    logic [2:0]  d_tag  [4];
    logic [31:0] d_data [4];

    // reference model: one outstanding result per source, rotating priority
    bit          m_pend  [4];
    logic [2:0]  m_tag   [4];
    logic [31:0] m_data  [4];
    int          m_rr;
    bit          m_cv;
    logic [2:0]  m_ctag;
    logic [31:0] m_cdata;
    logic [3:0]  m_ready;
    logic [3:0]  m_acc;
    logic [3:0]  seen_ready;

    typedef struct {
        bit         fl;
        logic [3:0] v;
        logic [2:0] t0, t1, t2, t3;
        logic [3:0] er;
        bit         ecv;
        logic [2:0] etag;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] dval(input logic [2:0] t);
        return 32'hC0DE_0000 + {29'd0, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock cycle: drive, check ready mid-cycle, advance model, check broadcast
    task automatic step();
        int win;
        int j;
        rst           = d_rst;
        flush         = d_flush;
        bus.src_valid = d_valid;
        for (int i = 0; i < 4; i++) begin
            bus.src_tag[i*3 +: 3]   = d_tag[i];
            bus.src_data[i*32 +: 32] = d_data[i];
        end
        @(negedge clk);
        win = -1;
        for (int k = 0; k < 4; k++) begin
            j = (m_rr + k) % 4;
            if (win < 0 && m_pend[j]) win = j;
        end
        for (int i = 0; i < 4; i++) begin
            m_ready[i] = !d_flush && (!m_pend[i] || win == i);
            m_acc[i]   = d_valid[i] && m_ready[i] && !d_rst;
        end
        seen_ready = bus.src_ready;
        if (!d_rst) chk("src_ready", {28'd0, bus.src_ready}, {28'd0, m_ready});
        @(posedge clk);
        if (d_rst) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            m_rr = 0; m_cv = 1'b0; m_ctag = '0; m_cdata = '0;
        end else if (d_flush) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            m_cv = 1'b0;
        end else begin
            if (win >= 0) begin
                m_cv = 1'b1; m_ctag = m_tag[win]; m_cdata = m_data[win];
                m_pend[win] = 1'b0;
                m_rr = (win + 1) % 4;
            end else begin
                m_cv = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_acc[i]) begin
                    m_pend[i] = 1'b1; m_tag[i] = d_tag[i]; m_data[i] = d_data[i];
                end
            end
        end
        #1;
        chk("cdb_valid", {31'd0, bus.cdb_valid}, {31'd0, m_cv});
        if (m_cv || d_rst) begin
            chk("cdb_tag", {29'd0, bus.cdb_tag}, {29'd0, m_ctag});
            chk("cdb_data", bus.cdb_data, m_cdata);
        end
    endtask

    initial begin
        bit prev;

        tbl[0]  = '{0, 4'b1111, 0, 1, 2, 3, 4'b1111, 0, 0};
        tbl[1]  = '{0, 4'b0000, 0, 0, 0, 0, 4'b0001, 1, 0};
        tbl[2]  = '{0, 4'b0000, 0, 0, 0, 0, 4'b0011, 1, 1};
        tbl[3]  = '{0, 4'b0000, 0, 0, 0, 0, 4'b0111, 1, 2};
        tbl[4]  = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 3};
        tbl[5]  = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0};
        tbl[6]  = '{0, 4'b1000, 0, 0, 0, 5, 4'b1111, 0, 0};
        tbl[7]  = '{0, 4'b1000, 0, 0, 0, 6, 4'b1111, 1, 5};
        tbl[8]  = '{0, 4'b1000, 0, 0, 0, 7, 4'b1111, 1, 6};
        tbl[9]  = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 7};
        tbl[10] = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0};
        tbl[11] = '{0, 4'b0111, 1, 2, 4, 0, 4'b1111, 0, 0};
        tbl[12] = '{1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0};
        tbl[13] = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0};
        tbl[14] = '{0, 4'b0001, 6, 0, 0, 0, 4'b1111, 0, 0};
        tbl[15] = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 1, 6};
        tbl[16] = '{0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0};

        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
            d_tag[i] = 3'(i); d_data[i] = dval(3'(i));
        end
        m_rr = 0; m_cv = 1'b0; m_ctag = '0; m_cdata = '0; m_acc = '0;

        // reset with all sources requesting
        d_rst = 1'b1; d_flush = 1'b0; d_valid = 4'b1111;
        repeat (2) begin
            step();
            chk("reset_cdb_valid", {31'd0, bus.cdb_valid}, 32'd0);
        end
        d_rst = 1'b0; d_valid = 4'b0000;
        step();
        chk("ready_after_reset", {28'd0, seen_ready}, 32'hF);

        // contention, reload-on-grant, flush
        for (int n = 0; n < 17; n++) begin
            d_flush = tbl[n].fl;
            d_valid = tbl[n].v;
            d_tag[0] = tbl[n].t0; d_tag[1] = tbl[n].t1;
            d_tag[2] = tbl[n].t2; d_tag[3] = tbl[n].t3;
            for (int i = 0; i < 4; i++) d_data[i] = dval(d_tag[i]);
            step();
            chk("tbl_ready", {28'd0, seen_ready}, {28'd0, tbl[n].er});
            chk("tbl_cdb_valid", {31'd0, bus.cdb_valid}, {31'd0, tbl[n].ecv});
            if (tbl[n].ecv) begin
                chk("tbl_cdb_tag", {29'd0, bus.cdb_tag}, {29'd0, tbl[n].etag});
                chk("tbl_cdb_data", bus.cdb_data, dval(tbl[n].etag));
            end
        end
        d_flush = 1'b0;

        // single result latency
        d_valid = 4'b0100; d_tag[2] = 3'd5; d_data[2] = 32'hDEADBEEF;
        step();
        chk("single_accept", {31'd0, seen_ready[2]}, 32'd1);
        chk("single_not_yet", {31'd0, bus.cdb_valid}, 32'd0);
        d_valid = 4'b0000;
        step();
        chk("single_valid", {31'd0, bus.cdb_valid}, 32'd1);
        chk("single_tag", {29'd0, bus.cdb_tag}, 32'd5);
        chk("single_data", bus.cdb_data, 32'hDEADBEEF);
        step();
        chk("single_pulse", {31'd0, bus.cdb_valid}, 32'd0);

        // fairness: src0 even tags, src1 odd tags, both always requesting
        d_valid = 4'b0011;
        d_tag[0] = 3'd0; d_tag[1] = 3'd1;
        d_data[0] = dval(3'd0); d_data[1] = dval(3'd1);
        prev = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c >= 1) chk("fair_valid", {31'd0, bus.cdb_valid}, 32'd1);
            if (c >= 2) chk("fair_alternate", {31'd0, bus.cdb_tag[0]}, {31'd0, ~prev});
            prev = bus.cdb_tag[0];
            for (int i = 0; i < 2; i++) begin
                if (seen_ready[i]) begin
                    d_tag[i] = d_tag[i] + 3'd2;
                    d_data[i] = dval(d_tag[i]);
                end
            end
        end
        d_valid = 4'b0000;
        repeat (3) step();

        // randomized traffic with hold-until-accepted sources and occasional flush
        m_acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!d_valid[i] || m_acc[i]) begin
                    d_valid[i] = ($urandom_range(0, 2) != 0);
                    d_tag[i]   = 3'($urandom);
                    d_data[i]  = $urandom;
                end
            end
            d_flush = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
